// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration-counter width rule.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 8;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int div_cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand and result handshakes of the divider bundled as one interface.
// master = producer/consumer side, slave = divider side.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference only
// when it is non-negative, and shift the resulting quotient bit into Q.
// The stored remainder is always below the divisor, so only its low WIDTH
// bits are carried; the extra bit lives only in the shifted/trial values.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Trial subtraction and restore decision.
  always_comb begin
    shifted_s = {r_i, q_i[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, d_i};
    if (trial_s[WIDTH] == 1'b0) begin
      r_o = trial_s[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = shifted_s[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider. Accepts an unsigned operand pair,
// produces one quotient bit per clock and presents quotient, remainder and a
// divide-by-zero flag until the consumer takes them. A zero divisor skips the
// iteration and reports all-ones quotient with the dividend as remainder.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic                     clk,
  input logic                     n_rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int             CW       = div_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r_s;
  logic [WIDTH-1:0] step_q_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dsr_q),
    .r_o (step_r_s),
    .q_o (step_q_s)
  );

  // Next-state and datapath control; result registers load on entry to DONE.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          q_d        = bus.dividend;
          dsr_d      = bus.divisor;
          r_d        = '0;
          cnt_d      = '0;
          zero_d     = (bus.divisor == '0);
          in_ready_d = 1'b0;
          state_d    = CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CALC: begin
        if (zero_q) begin
          // Single bookkeeping cycle; q_q still holds the latched dividend.
          quot_d      = '1;
          rem_d       = q_q;
          dbz_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          r_d   = step_r_s;
          q_d   = step_q_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            quot_d      = step_q_s;
            rem_d       = step_r_s;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector bench for seq_restoring_divider (WIDTH=8): table of operand
// pairs with hand-computed results and latencies, plus backpressure, reset
// mid-calculation and a randomized regression against a reference divide.
module tb_seq_restoring_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one operand pair at a negedge, scramble operands during the
  // calculation, measure latency in edges after the accept edge, then consume.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = v.dvd;
    bus.divisor   = v.dsr;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    check({tag, " in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " quotient"}, {24'd0, bus.quotient}, {24'd0, v.q});
    check({tag, " remainder"}, {24'd0, bus.remainder}, {24'd0, v.r});
    check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, v.z});
    @(negedge clk);
    check({tag, " out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int seen;
    int cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;

    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[2]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 8};
    vecs[3]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
    vecs[4]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[5]  = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1, 1};
    vecs[6]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
    vecs[7]  = '{8'd77,  8'd6,   8'd12,  8'd5,   1'b0, 8};
    vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
    vecs[9]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8};
    vecs[10] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0, 8};
    vecs[11] = '{8'd1,   8'd0,   8'd255, 8'd1,   1'b1, 1};

    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset quotient", {24'd0, bus.quotient}, 32'd0);
    check("reset remainder", {24'd0, bus.remainder}, 32'd0);
    check("reset div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
    n_rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: 100/9 = 11 r1 held for five stalled cycles while a
    // competing operand pair is offered and must not be accepted.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'd100;
    bus.divisor   = 8'd9;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.dividend = 8'd3;
    bus.divisor  = 8'd1;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", 32'(cyc), 32'd8);
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp quotient", {24'd0, bus.quotient}, 32'd11);
      check("bp remainder", {24'd0, bus.remainder}, 32'd1);
      check("bp div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("bp out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("bp in_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // Reset while the counter is at 4 during 77/6.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("rst_mid out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid quotient", {24'd0, bus.quotient}, 32'd0);
    check("rst_mid remainder", {24'd0, bus.remainder}, 32'd0);
    check("rst_mid div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("rst_mid no_stale_result", 32'(seen), 32'd0);
    run_vec('{8'd77, 8'd6, 8'd12, 8'd5, 1'b0, 8}, "after_rst");

    // Randomized regression with input gaps, consumer stalls and operand
    // churn during the calculation.
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(255, 1));
      exp_q = a / b;
      exp_r = a % b;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
        bus.in_valid  = 1'($urandom_range(1, 0));
        bus.dividend  = 8'($urandom);
        bus.divisor   = 8'($urandom);
        bus.out_ready = 1'($urandom_range(1, 0));
        @(negedge clk);
        cyc++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("rnd out_valid", {31'd0, bus.out_valid}, 32'd1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      check("rnd quotient", {24'd0, bus.quotient}, {24'd0, exp_q});
      check("rnd remainder", {24'd0, bus.remainder}, {24'd0, exp_r});
      check("rnd invariant",
            {31'd0, ((32'(bus.quotient) * 32'(b) + 32'(bus.remainder)) == 32'(a))
                    && (bus.remainder < b)},
            32'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
